// File: rtl/lrhls_top_div_33s_17ns_18s_seq.sv
// Sequential signed/unsigned divider: 33-bit signed dividend by 17-bit unsigned divisor.
// Radix-2 non-restoring on magnitudes; fixed 35-cycle latency from accept to out_valid.
module lrhls_top_div_33s_17ns_18s_seq #(
    parameter int DIVIDEND_W = 33,
    parameter int DIVISOR_W  = 17,
    parameter int QUOTIENT_W = 18
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOTIENT_W-1:0] quotient,
    output logic [QUOTIENT_W-1:0] remainder,
    output logic                  ovf,
    output logic                  div0
);

    localparam int RW = DIVISOR_W + 3;
    localparam int CW = $clog2(DIVIDEND_W);
    localparam logic [DIVIDEND_W-1:0] POS_LIM = DIVIDEND_W'((64'd1 << (QUOTIENT_W - 1)) - 64'd1);
    localparam logic [DIVIDEND_W-1:0] NEG_LIM = POS_LIM + DIVIDEND_W'(1);
    localparam logic [QUOTIENT_W-1:0] Q_MAX = {1'b0, {(QUOTIENT_W-1){1'b1}}};
    localparam logic [QUOTIENT_W-1:0] Q_MIN = {1'b1, {(QUOTIENT_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_cnt;
    logic [DIVIDEND_W-1:0]   r_acc;
    logic [RW-1:0]           r_part;
    logic [DIVISOR_W-1:0]    r_divisor;
    logic                    r_neg;
    logic                    r_inReady;
    logic                    r_outValid;
    logic [QUOTIENT_W-1:0]   r_quotient;
    logic [QUOTIENT_W-1:0]   r_remainder;
    logic                    r_ovf;
    logic                    r_div0;

    logic [DIVIDEND_W-1:0]   w_absDividend;
    logic [RW-1:0]           w_divExt;
    logic [RW-1:0]           w_shift;
    logic [RW-1:0]           w_step;
    logic [QUOTIENT_W-1:0]   w_remMag;
    logic [QUOTIENT_W-1:0]   w_remOut;

    // r_acc starts as the dividend magnitude and fills with quotient bits from the bottom.
    assign w_absDividend = dividend[DIVIDEND_W-1] ? -dividend : dividend;
    assign w_divExt      = {{(RW-DIVISOR_W){1'b0}}, r_divisor};
    assign w_shift       = {r_part[RW-2:0], r_acc[DIVIDEND_W-1]};
    assign w_step        = r_part[RW-1] ? (w_shift + w_divExt) : (w_shift - w_divExt);
    assign w_remMag      = r_part[RW-1] ? QUOTIENT_W'(r_part + w_divExt) : QUOTIENT_W'(r_part);
    assign w_remOut      = r_neg ? -w_remMag : w_remMag;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_part      <= '0;
            r_divisor   <= '0;
            r_neg       <= 1'b0;
            r_inReady   <= 1'b0;
            r_outValid  <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_ovf       <= 1'b0;
            r_div0      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_inReady <= 1'b1;
                    if (in_valid && r_inReady) begin
                        r_acc     <= w_absDividend;
                        r_divisor <= divisor;
                        r_neg     <= dividend[DIVIDEND_W-1];
                        r_part    <= '0;
                        r_cnt     <= '0;
                        r_inReady <= 1'b0;
                        r_state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_part <= w_step;
                    r_acc  <= {r_acc[DIVIDEND_W-2:0], ~w_step[RW-1]};
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == CW'(DIVIDEND_W - 1))
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_state <= S_DONE;
                    if (r_divisor == '0) begin
                        r_div0      <= 1'b1;
                        r_ovf       <= 1'b0;
                        r_remainder <= '0;
                        r_quotient  <= r_neg ? Q_MIN : Q_MAX;
                    end else begin
                        r_div0      <= 1'b0;
                        r_remainder <= w_remOut;
                        if (!r_neg) begin
                            r_ovf      <= (r_acc > POS_LIM);
                            r_quotient <= (r_acc > POS_LIM) ? Q_MAX : r_acc[QUOTIENT_W-1:0];
                        end else begin
                            r_ovf      <= (r_acc > NEG_LIM);
                            r_quotient <= (r_acc > NEG_LIM) ? Q_MIN : -r_acc[QUOTIENT_W-1:0];
                        end
                    end
                end
                S_DONE: begin
                    // out_valid rises one cycle after the results settle, fixing latency at 35.
                    if (!r_outValid) begin
                        r_outValid <= 1'b1;
                    end else if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign ovf       = r_ovf;
    assign div0      = r_div0;

endmodule
